// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the CPU-to-RAM bus bridge.
package mem_bridge_pkg;
  localparam int BYTE_LANES = 4;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_MERGE} state_t;

  function automatic logic be_full(input logic [BYTE_LANES-1:0] be);
    return &be;
  endfunction
endpackage

// File: rtl/bridge_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take the new word, others keep the old.
module bridge_byte_merge
  import mem_bridge_pkg::*;
(
  input  logic [DATA_W-1:0]     old_word,
  input  logic [DATA_W-1:0]     new_word,
  input  logic [BYTE_LANES-1:0] be,
  output logic [DATA_W-1:0]     merged
);
  for (genvar i = 0; i < BYTE_LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/mem_bus_bridge.sv
// Byte-addressed waitrequest bus to word-addressed RAM bridge with read-modify-write.
// Optional address range check and sticky err flag under `BRIDGE_RANGE_CHECK_EN.
module mem_bus_bridge
  import mem_bridge_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WORD_ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            address,
  input  logic                   read,
  input  logic                   write,
  input  logic [DATA_W-1:0]      writedata,
  input  logic [BYTE_LANES-1:0]  byteenable,
  output logic                   waitrequest,
  output logic [DATA_W-1:0]      readdata,
  output logic                   err,
  output logic [WORD_ADDR_W-1:0] ram_address,
  output logic                   ram_read,
  output logic                   ram_write,
  output logic [DATA_W-1:0]      ram_writedata,
  input  logic [DATA_W-1:0]      ram_readdata
);
  state_t            state, next;
  logic [DATA_W-1:0] readdata_q, merged;
  logic [31:0]       offset;
  logic              in_range, oor, complete, rd_done, rd_c, wr_c;

  assign offset      = address - ADDR_BASE;
  assign ram_address = WORD_ADDR_W'(offset >> 2);

`ifdef BRIDGE_RANGE_CHECK_EN
  logic [32:0] limit;
  logic        err_q;
  assign limit    = {1'b0, ADDR_BASE} + (33'd4 << WORD_ADDR_W);
  assign in_range = (address >= ADDR_BASE) && ({1'b0, address} < limit);
  assign err      = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   err_q <= 1'b0;
    else if (oor) err_q <= 1'b1;
  end
`else
  assign in_range = 1'b1;
  assign err      = 1'b0;
`endif

  bridge_byte_merge u_merge (
    .old_word (ram_readdata),
    .new_word (writedata),
    .be       (byteenable),
    .merged   (merged)
  );

  always_comb begin
    next     = state;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    complete = 1'b0;
    rd_done  = 1'b0;
    oor      = 1'b0;
    case (state)
      IDLE: begin
        // write takes priority; a simultaneous read is ignored
        if (write) begin
          if (!in_range) begin
            oor      = 1'b1;
            complete = 1'b1;
          end else if (byteenable == '0) begin
            complete = 1'b1;
          end else if (be_full(byteenable)) begin
            wr_c     = 1'b1;
            complete = 1'b1;
          end else begin
            rd_c = 1'b1;
            next = RMW_MERGE;
          end
        end else if (read) begin
          if (!in_range) begin
            oor      = 1'b1;
            complete = 1'b1;
          end else begin
            rd_c = 1'b1;
            next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        next = IDLE;
        if (read) begin
          rd_done  = 1'b1;
          complete = 1'b1;
        end
      end
      RMW_MERGE: begin
        next = IDLE;
        if (write) begin
          wr_c     = 1'b1;
          complete = 1'b1;
        end
      end
      default: next = IDLE;
    endcase
  end

  // strobes are forced quiet while reset is held, independent of state
  assign ram_read      = rst_n & rd_c;
  assign ram_write     = rst_n & wr_c;
  assign waitrequest   = ~rst_n | ((read | write) & ~complete);
  assign ram_writedata = (state == RMW_MERGE) ? merged : writedata;
  assign readdata      = (oor & ~write) ? '0 : (rd_done ? ram_readdata : readdata_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      readdata_q <= '0;
    end else begin
      state <= next;
      if (rd_done) readdata_q <= ram_readdata;
    end
  end
endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed self-checking bench for mem_bus_bridge with a 1-cycle registered RAM model.
module tb_mem_bus_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address, writedata, readdata, ram_writedata, ram_readdata, rd;
  logic        read, write, waitrequest, err, ram_read, ram_write;
  logic [3:0]  byteenable;
  logic [11:0] ram_address;
  logic [31:0] mem [0:4095];
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_bus_bridge dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .err           (err),
    .ram_address   (ram_address),
    .ram_read      (ram_read),
    .ram_write     (ram_write),
    .ram_writedata (ram_writedata),
    .ram_readdata  (ram_readdata)
  );

  initial ram_readdata = '0;
  always @(posedge clk) begin
    if (ram_write) mem[ram_address] <= ram_writedata;
    if (ram_read)  ram_readdata     <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // waits (bounded) for completion, captures readdata, then steps past the edge
  task automatic wait_done(input string tag, output logic [31:0] d);
    bit ok = 0;
    d = 'x;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        ok = 1;
        d  = readdata;
        break;
      end
    end
    if (!ok) chk({tag, "_timeout"}, {31'b0, waitrequest}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] dummy;
    address = a; writedata = d; byteenable = b; write = 1'b1; read = 1'b0;
    wait_done("wr", dummy);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address = a; read = 1'b1; write = 1'b0;
    wait_done("rd", d);
    read = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    @(negedge clk);
    chk("rst_wait",  {31'b0, waitrequest}, 32'h1);
    chk("rst_rd",    {31'b0, ram_read},    32'h0);
    chk("rst_wr",    {31'b0, ram_write},   32'h0);
    chk("rst_rdata", readdata,             32'h0);
    chk("rst_err",   {31'b0, err},         32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // full write, zero wait states, then read back
    address = 32'h10; writedata = 32'hDEADBEEF; byteenable = 4'hF; write = 1'b1;
    @(negedge clk);
    chk("fw_addr",  {20'b0, ram_address}, 32'h4);
    chk("fw_wr",    {31'b0, ram_write},   32'h1);
    chk("fw_rd",    {31'b0, ram_read},    32'h0);
    chk("fw_wdata", ram_writedata,        32'hDEADBEEF);
    chk("fw_wait",  {31'b0, waitrequest}, 32'h0);
    @(posedge clk); #1 write = 1'b0; read = 1'b1;
    @(negedge clk);
    chk("rd_wait1", {31'b0, waitrequest}, 32'h1);
    chk("rd_strb",  {31'b0, ram_read},    32'h1);
    @(negedge clk);
    chk("rd_wait0", {31'b0, waitrequest}, 32'h0);
    chk("rd_data",  readdata,             32'hDEADBEEF);
    @(posedge clk); #1 read = 1'b0;
    @(negedge clk);
    chk("rd_hold",  readdata,             32'hDEADBEEF);
    @(posedge clk); #1;

    // partial write: read-modify-write on lane 1
    address = 32'h10; writedata = 32'h0000AB00; byteenable = 4'b0010; write = 1'b1;
    @(negedge clk);
    chk("rmw_rd",   {31'b0, ram_read},    32'h1);
    chk("rmw_wr0",  {31'b0, ram_write},   32'h0);
    chk("rmw_w1",   {31'b0, waitrequest}, 32'h1);
    @(negedge clk);
    chk("rmw_wr1",  {31'b0, ram_write},   32'h1);
    chk("rmw_data", ram_writedata,        32'hDEADABEF);
    chk("rmw_w0",   {31'b0, waitrequest}, 32'h0);
    @(posedge clk); #1 write = 1'b0;
    bus_read(32'h10, rd);
    chk("rmw_back", rd, 32'hDEADABEF);

    // async reset in the middle of a merge must suppress the write
    address = 32'h10; writedata = 32'h00770000; byteenable = 4'b0100; write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_pre",  {31'b0, ram_write},  32'h1);
    chk("mrst_mrg",  ram_writedata,       32'hDE77ABEF);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_wr",   {31'b0, ram_write},  32'h0);
    chk("mrst_wait", {31'b0, waitrequest}, 32'h1);
    chk("mrst_rdat", readdata,            32'h0);
    chk("mrst_err",  {31'b0, err},        32'h0);
    @(posedge clk); #1 write = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_idle", {31'b0, waitrequest}, 32'h0);
    @(posedge clk); #1;
    bus_read(32'h10, rd);
    chk("mrst_back", rd, 32'hDEADABEF);

    // empty write
    address = 32'h20; writedata = 32'hFFFFFFFF; byteenable = 4'h0; write = 1'b1;
    @(negedge clk);
    chk("ew_rd",   {31'b0, ram_read},    32'h0);
    chk("ew_wr",   {31'b0, ram_write},   32'h0);
    chk("ew_wait", {31'b0, waitrequest}, 32'h0);
    @(posedge clk); #1 write = 1'b0;

    // read and write together: write wins
    address = 32'h30; writedata = 32'h12345678; byteenable = 4'hF; write = 1'b1; read = 1'b1;
    @(negedge clk);
    chk("rw_wr",   {31'b0, ram_write},   32'h1);
    chk("rw_rd",   {31'b0, ram_read},    32'h0);
    chk("rw_wait", {31'b0, waitrequest}, 32'h0);
    chk("rw_addr", {20'b0, ram_address}, 32'hC);
    @(posedge clk); #1 write = 1'b0; read = 1'b0;
    bus_read(32'h30, rd);
    chk("rw_back", rd, 32'h12345678);

    // read dropped in RD_WAIT: readdata keeps the previous value
    address = 32'h10; read = 1'b1;
    @(posedge clk); #1 read = 1'b0;
    @(negedge clk);
    chk("ab_rdata", readdata,             32'h12345678);
    chk("ab_wait",  {31'b0, waitrequest}, 32'h0);
    @(posedge clk); #1;

    // write dropped in RMW_MERGE: no RAM write
    address = 32'h10; writedata = 32'h000000FF; byteenable = 4'b0001; write = 1'b1;
    @(posedge clk); #1 write = 1'b0;
    @(negedge clk);
    chk("abw_wr", {31'b0, ram_write}, 32'h0);
    @(posedge clk); #1;
    bus_read(32'h10, rd);
    chk("abw_back", rd, 32'hDEADABEF);

    // access beyond the RAM window
    bus_write(32'h0, 32'hCAFEF00D, 4'hF);
`ifdef BRIDGE_RANGE_CHECK_EN
    address = 32'h4000; read = 1'b1;
    @(negedge clk);
    chk("oor_rd",    {31'b0, ram_read},    32'h0);
    chk("oor_wait",  {31'b0, waitrequest}, 32'h0);
    chk("oor_rdata", readdata,             32'h0);
    chk("oor_err0",  {31'b0, err},         32'h0);
    @(posedge clk); #1 read = 1'b0;
    @(negedge clk);
    chk("oor_err1",  {31'b0, err},         32'h1);
    @(posedge clk); #1;
`else
    address = 32'h4000; read = 1'b1;
    @(negedge clk);
    chk("wrap_addr", {20'b0, ram_address}, 32'h0);
    chk("wrap_rd",   {31'b0, ram_read},    32'h1);
    @(posedge clk); #1 read = 1'b0;
    bus_read(32'h4000, rd);
    chk("wrap_data", rd,          32'hCAFEF00D);
    chk("wrap_err",  {31'b0, err}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
